// File: rtl/psum_gbf_reader_pkg.sv
// ---------------------------------------------------------------------------
// psum_rd_pkg
// Shared types and constants for the psum global-buffer read/drain engine.
//   state_t      : drain FSM states (IDLE, READ, WAIT, SEND, FREE)
//   BUF1 / BUF2  : buffer-number encoding, same as the writer's psum_gbf_w_num
//   beats()      : number of output beats per psum_gbf entry
// ---------------------------------------------------------------------------
package psum_rd_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      FREE = 3'd4
   } state_t;

   localparam logic BUF1 = 1'b0;
   localparam logic BUF2 = 1'b1;

   function automatic int beats(input int data_w, input int out_w);
      return data_w / out_w;
   endfunction

endpackage

// File: rtl/psum_gbf_reader_if.sv
// ---------------------------------------------------------------------------
// psum_gbf_reader_if
// Output beat stream from the psum drain engine toward the off-chip/DMA path.
//   out_valid : beat valid (source)
//   out_data  : beat payload, OUT_DATA_BITWIDTH wide (source)
//   out_last  : final beat of the drained buffer (source)
//   out_ready : sink accepts the beat (sink)
// Handshake: a beat transfers on a rising clock edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid, out_data and
// out_last hold steady until that transfer; out_valid never depends
// combinationally on out_ready.
// ---------------------------------------------------------------------------
interface psum_gbf_reader_if #(
   parameter int OUT_DATA_BITWIDTH = 128
);
   logic                         out_valid;
   logic [OUT_DATA_BITWIDTH-1:0] out_data;
   logic                         out_last;
   logic                         out_ready;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/psum_gbf_reader_serializer.sv
// ---------------------------------------------------------------------------
// psum_beat_serializer
// Holds one wide psum word and emits it as BEATS narrow beats, LSB slice first.
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture load_data into the hold register, start at beat 0
//   load_data    : wide psum word
//   load_last    : this word is the final entry of the buffer
//   out_ready    : sink accepts the current beat
//   out_valid    : beat valid
//   out_data     : current beat (low slice of the hold register)
//   out_last     : final beat of the final entry
//   done         : last beat of this word is transferring this cycle
// ---------------------------------------------------------------------------
module psum_beat_serializer
   import psum_rd_pkg::*;
#(
   parameter int DATA_W = 512,
   parameter int OUT_W  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              done
);
   localparam int BEATS  = beats(DATA_W, OUT_W);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   logic [DATA_W-1:0] hold;
   logic [BEAT_W-1:0] beat;
   logic              valid;
   logic              entry_last;
   logic              accept;

   assign accept = valid & out_ready;
   assign done   = accept & (beat == LAST_BEAT);

   // The hold register shifts right on each accepted beat so the current
   // beat is always the low slice; nothing moves while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold       <= '0;
         beat       <= '0;
         valid      <= 1'b0;
         entry_last <= 1'b0;
      end else if (load) begin
         hold       <= load_data;
         beat       <= '0;
         valid      <= 1'b1;
         entry_last <= load_last;
      end else if (accept) begin
         hold <= hold >> OUT_W;
         if (beat == LAST_BEAT) begin
            beat  <= '0;
            valid <= 1'b0;
         end else begin
            beat <= beat + BEAT_W'(1);
         end
      end
   end

   assign out_valid = valid;
   assign out_data  = hold[OUT_W-1:0];
   assign out_last  = valid & entry_last & (beat == LAST_BEAT);

endmodule

// File: rtl/psum_gbf_reader.sv
// ---------------------------------------------------------------------------
// psum_gbf_reader
// Drains completed psum_gbf buffers (buf1/buf2) entry by entry, serializes
// each wide entry into narrow beats and releases the buffer to the writer.
//   clk, reset          : clock, synchronous active-high reset
//   buf_done/_num       : completion pulse and buffer number (0=buf1, 1=buf2)
//   drain_len           : valid entries in the completed buffer
//   rd_en1/2, rd_addr   : psum_gbf read port (1-cycle read latency)
//   rd_data1/2          : psum_gbf read data
//   out_if (master)     : output beat stream (valid/ready, data, last)
//   buf1_free/buf2_free : one-cycle release pulses
//   overrun             : sticky, buf_done hit a pending/draining buffer
//   clr_en/num/addr     : zero-write port, active only with PSUM_RD_CLEAR_EN
//   fsm_state           : current FSM state, for debug
// Build option: define PSUM_RD_CLEAR_EN to zero every entry as it is drained;
// otherwise the clear port is tied to zero.
// ---------------------------------------------------------------------------
module psum_gbf_reader
   import psum_rd_pkg::*;
#(
   parameter int PSUM_GBF_DATA_BITWIDTH = 512,
   parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
   parameter int PSUM_GBF_DEPTH         = 32,
   parameter int OUT_DATA_BITWIDTH      = 128
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              buf_done,
   input  logic                              buf_done_num,
   input  logic [PSUM_GBF_ADDR_BITWIDTH:0]   drain_len,
   output logic                              rd_en1,
   output logic                              rd_en2,
   output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] rd_addr,
   input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] rd_data1,
   input  logic [PSUM_GBF_DATA_BITWIDTH-1:0] rd_data2,
   psum_gbf_reader_if.master                 out_if,
   output logic                              buf1_free,
   output logic                              buf2_free,
   output logic                              overrun,
   output logic                              clr_en,
   output logic                              clr_num,
   output logic [PSUM_GBF_ADDR_BITWIDTH-1:0] clr_addr,
   output state_t                            fsm_state
);
   localparam int LEN_W = PSUM_GBF_ADDR_BITWIDTH + 1;

   state_t           state, next_state;
   logic [1:0]       pending, pending_next;
   logic [LEN_W-1:0] len_q [2];
   logic [LEN_W-1:0] len_clamped;
   logic [LEN_W-1:0] entry;
   logic             sel, pick, last_served, overrun_q;
   logic             done_accept, entry_last;
   logic             ser_load, ser_done;

   assign len_clamped = (drain_len > LEN_W'(PSUM_GBF_DEPTH)) ? LEN_W'(PSUM_GBF_DEPTH) : drain_len;
   // Pending stays set through the whole drain, so a repeat buf_done for the
   // buffer being read (including its FREE cycle) is caught as overrun.
   assign done_accept = buf_done & ~pending[buf_done_num];
   // Both pending: alternate away from the buffer served last.
   assign pick       = (&pending) ? ~last_served : pending[1];
   assign entry_last = (entry == len_q[sel] - LEN_W'(1));

   always_comb begin
      pending_next = pending;
      if (state == FREE) pending_next[sel] = 1'b0;
      if (done_accept)   pending_next[buf_done_num] = 1'b1;
   end

   always_comb begin
      next_state = state;
      ser_load   = 1'b0;
      case (state)
         IDLE: if (|pending) next_state = (len_q[pick] != '0) ? READ : FREE;
         READ: next_state = WAIT;
         WAIT: begin
            ser_load   = 1'b1;
            next_state = SEND;
         end
         SEND: if (ser_done) next_state = entry_last ? FREE : READ;
         FREE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pending     <= 2'b00;
         len_q       <= '{default: '0};
         entry       <= '0;
         sel         <= BUF1;
         last_served <= BUF2;
         overrun_q   <= 1'b0;
      end else begin
         state   <= next_state;
         pending <= pending_next;
         if (done_accept) len_q[buf_done_num] <= len_clamped;
         if (buf_done && pending[buf_done_num]) overrun_q <= 1'b1;
         if (state == IDLE && |pending) begin
            sel   <= pick;
            entry <= '0;
         end
         if (state == SEND && ser_done && !entry_last) entry <= entry + LEN_W'(1);
         if (state == FREE) last_served <= sel;
      end
   end

   psum_beat_serializer #(
      .DATA_W (PSUM_GBF_DATA_BITWIDTH),
      .OUT_W  (OUT_DATA_BITWIDTH)
   ) u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .load_data ((sel == BUF2) ? rd_data2 : rd_data1),
      .load_last (entry_last),
      .out_ready (out_if.out_ready),
      .out_valid (out_if.out_valid),
      .out_data  (out_if.out_data),
      .out_last  (out_if.out_last),
      .done      (ser_done)
   );

   assign rd_en1    = (state == READ) && (sel == BUF1);
   assign rd_en2    = (state == READ) && (sel == BUF2);
   assign rd_addr   = entry[PSUM_GBF_ADDR_BITWIDTH-1:0];
   assign buf1_free = (state == FREE) && (sel == BUF1);
   assign buf2_free = (state == FREE) && (sel == BUF2);
   assign overrun   = overrun_q;
   assign fsm_state = state;

`ifdef PSUM_RD_CLEAR_EN
   // WAIT follows READ directly and entry has not moved yet, so entry is
   // the address just read; the psum_gbf port must be read-first.
   assign clr_en   = (state == WAIT);
   assign clr_num  = (state == WAIT) ? sel : 1'b0;
   assign clr_addr = (state == WAIT) ? entry[PSUM_GBF_ADDR_BITWIDTH-1:0] : '0;
`else
   assign clr_en   = 1'b0;
   assign clr_num  = 1'b0;
   assign clr_addr = '0;
`endif

endmodule

// File: tb/tb_psum_gbf_reader.sv
// ---------------------------------------------------------------------------
// tb_psum_gbf_reader
// Directed bench for psum_gbf_reader (BEATS = 4). A memory model serves
// rd_data with 1-cycle latency; expected beats, reads and free pulses are
// queued from the drain rules and compared every cycle by one monitor.
// ---------------------------------------------------------------------------
module tb_psum_gbf_reader;
  import psum_rd_pkg::*;

  localparam int DW = 512;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int OW = 128;
  localparam int BEATS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          buf_done = 1'b0;
  logic          buf_done_num = 1'b0;
  logic [AW:0]   drain_len = '0;
  logic          rd_en1, rd_en2;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data1 = '0;
  logic [DW-1:0] rd_data2 = '0;
  logic          buf1_free, buf2_free, overrun, clr_en, clr_num;
  logic [AW-1:0] clr_addr;
  state_t        fsm_state;

  psum_gbf_reader_if #(.OUT_DATA_BITWIDTH(OW)) out_if ();

  psum_gbf_reader #(
    .PSUM_GBF_DATA_BITWIDTH(DW), .PSUM_GBF_ADDR_BITWIDTH(AW),
    .PSUM_GBF_DEPTH(DEPTH), .OUT_DATA_BITWIDTH(OW)
  ) dut (
    .clk(clk), .reset(reset), .buf_done(buf_done), .buf_done_num(buf_done_num),
    .drain_len(drain_len), .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_addr(rd_addr),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .out_if(out_if),
    .buf1_free(buf1_free), .buf2_free(buf2_free), .overrun(overrun),
    .clr_en(clr_en), .clr_num(clr_num), .clr_addr(clr_addr), .fsm_state(fsm_state)
  );

  // ---------------- memory content rule ----------------
  // 32-bit word w of entry a in buffer b = {A0|b, a, w}
  function automatic logic [31:0] word_of(input logic b, input int a, input int w);
    logic [7:0] tag;
    tag = 8'hA0 | {7'd0, b};
    return {tag, a[7:0], w[15:0]};
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic b, input int a);
    logic [DW-1:0] m;
    for (int w = 0; w < DW / 32; w++) m[w*32 +: 32] = word_of(b, a, w);
    return m;
  endfunction

  // beat k of entry a carries words 4k..4k+3
  function automatic logic [OW-1:0] beat_val(input logic b, input int a, input int k);
    logic [OW-1:0] v;
    for (int j = 0; j < OW / 32; j++) v[j*32 +: 32] = word_of(b, a, k * (OW / 32) + j);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem_word(1'b0, int'(rd_addr));
    if (rd_en2) rd_data2 <= mem_word(1'b1, int'(rd_addr));
  end

  // ---------------- scoreboard ----------------
  logic [OW:0]   exp_q[$];       // {last, data}
  logic [AW:0]   exp_rd_q[$];    // {buf, addr}
  logic          exp_free_q[$];
  logic          exp_overrun = 1'b0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [159:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  task automatic expect_drain(input logic b, input int len);
    int l;
    l = (len > DEPTH) ? DEPTH : len;
    for (int a = 0; a < l; a++) begin
      exp_rd_q.push_back({b, a[AW-1:0]});
      for (int k = 0; k < BEATS; k++)
        exp_q.push_back({(a == l - 1) && (k == BEATS - 1), beat_val(b, a, k)});
    end
    exp_free_q.push_back(b);
  endtask

  // ---------------- monitor / compare ----------------
  int first_valid_cyc = -1;
  int last_cyc = -1;
  int free_cyc = -1;
  int stall_cnt = 0;
  int rd_cnt = 0;
  logic got_first = 1'b0;
  logic [OW:0] first_beat = '0;
  logic [OW:0] last_beat = '0;
  logic stall_prev = 1'b0;
  logic [OW:0] stall_val = '0;
  logic prev_rd = 1'b0;
  logic [AW:0] prev_rd_tag = '0;

  always @(negedge clk) begin
    logic [OW:0] e;
    logic [OW:0] cur;
    logic [AW:0] r;
    logic f;
    cur = {out_if.out_last, out_if.out_data};
    if (reset) begin
      stall_prev = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", out_if.out_valid, 1'b1);
        check("stall_hold", cur, stall_val);
      end
      stall_prev = out_if.out_valid & ~out_if.out_ready;
      stall_val = cur;
      if (stall_prev) stall_cnt++;
      if (out_if.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_if.out_valid && out_if.out_ready) begin
        if (!got_first) begin
          first_beat = cur;
          got_first = 1'b1;
        end
        last_beat = cur;
        if (out_if.out_last) last_cyc = cyc;
        if (exp_q.size() == 0) report_fail("beat_unexpected", cur);
        else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
      end
      if (rd_en1 || rd_en2) begin
        rd_cnt++;
        check("rd_one_hot", rd_en1 & rd_en2, 1'b0);
        check("rd_during_send", out_if.out_valid, 1'b0);
        if (exp_rd_q.size() == 0) report_fail("rd_unexpected", {rd_en2, rd_addr});
        else begin
          r = exp_rd_q.pop_front();
          check("rd_target", {rd_en2, rd_addr}, r);
        end
      end
      if (buf1_free || buf2_free) begin
        free_cyc = cyc;
        check("free_one_hot", buf1_free & buf2_free, 1'b0);
        if (exp_free_q.size() == 0) report_fail("free_unexpected", {buf2_free, buf1_free});
        else begin
          f = exp_free_q.pop_front();
          check("free_buf", buf2_free, f);
        end
      end
      check("overrun", overrun, exp_overrun);
`ifdef PSUM_RD_CLEAR_EN
      check("clr_en", clr_en, prev_rd);
      if (clr_en) check("clr_target", {clr_num, clr_addr}, prev_rd_tag);
`else
      check("clr_off", {clr_en, clr_num, clr_addr}, '0);
`endif
      prev_rd = rd_en1 | rd_en2;
      prev_rd_tag = {rd_en2, rd_addr};
    end
  end

  // ---------------- driver tasks ----------------
  int done_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic b, input int len);
    buf_done = 1'b1;
    buf_done_num = b;
    drain_len = len[AW:0];
    done_cyc = cyc;
    tick();
    buf_done = 1'b0;
    drain_len = '0;
  endtask

  task automatic drain(input logic b, input int len);
    expect_drain(b, len);
    issue(b, len);
  endtask

  task automatic wait_drained(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && exp_rd_q.size() == 0 && exp_free_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) report_fail("drain_timeout", exp_q.size());
    repeat (3) tick();
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_if.out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) report_fail("valid_timeout", budget);
  endtask

  task automatic clear_marks();
    first_valid_cyc = -1;
    last_cyc = -1;
    free_cyc = -1;
    stall_cnt = 0;
    rd_cnt = 0;
    got_first = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {rd_en1, rd_en2, rd_addr, out_if.out_valid, out_if.out_data, out_if.out_last,
                 buf1_free, buf2_free, overrun, clr_en, clr_num, clr_addr}, '0);
    check({name, "_state"}, fsm_state, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    logic [OW:0] lit;
    out_if.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_reset_outputs("reset_values");

    // single buffer, len 2: 8 beats, latency 4, free 1 cycle after last
    clear_marks();
    drain(1'b0, 2);
    t0 = done_cyc;
    wait_drained(100);
    check("first_valid_latency", first_valid_cyc - t0, 4);
    check("free_after_last", free_cyc - last_cyc, 1);
    lit = {1'b0, 128'hA0000003_A0000002_A0000001_A0000000};
    check("first_beat_literal", first_beat, lit);
    lit = {1'b1, 128'hA001000F_A001000E_A001000D_A001000C};
    check("last_beat_literal", last_beat, lit);
    check("single_total_cycles", free_cyc - t0, 14);

    // back-to-back buf1 then buf2, two cycles apart
    clear_marks();
    drain(1'b0, 1);
    t0 = done_cyc;
    tick();
    drain(1'b1, 1);
    wait_drained(100);
    check("b2b_buf2_free_cycle", free_cyc - t0, 16);

    // buf_done for buf2 in the cycle buf1 is in FREE is accepted
    clear_marks();
    drain(1'b0, 1);
    repeat (7) tick();
    check("in_free_state", fsm_state, FREE);
    drain(1'b1, 1);
    wait_drained(100);

    // backpressure 1-0-0-1-0-1 during SEND
    clear_marks();
    drain(1'b0, 1);
    wait_valid(20);
    out_if.out_ready = 1'b1; tick();
    out_if.out_ready = 1'b0; tick();
    out_if.out_ready = 1'b0; tick();
    out_if.out_ready = 1'b1; tick();
    out_if.out_ready = 1'b0; tick();
    out_if.out_ready = 1'b1;
    wait_drained(100);
    check("stall_cycles", stall_cnt, 3);

    // len 0 on buf2: no beats, free 2 cycles after buf_done
    clear_marks();
    drain(1'b1, 0);
    t0 = done_cyc;
    wait_drained(20);
    check("len0_free_cycle", free_cyc - t0, 2);
    check("len0_no_valid", first_valid_cyc < 0, 1'b1);

    // len 40 clamps to 32 entries
    clear_marks();
    drain(1'b0, 40);
    wait_drained(400);
    check("clamp_reads", rd_cnt, 32);

    // second buf_done for the draining buffer: sticky overrun, drain unchanged
    clear_marks();
    drain(1'b1, 3);
    wait_valid(20);
    issue(1'b1, 5);
    exp_overrun = 1'b1;
    wait_drained(100);
    check("overrun_reads", rd_cnt, 3);
    check("overrun_sticky", overrun, 1'b1);

    // reset mid-SEND: outputs back to reset values, no free pulse
    clear_marks();
    drain(1'b0, 2);
    wait_valid(20);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_rd_q.delete();
    exp_free_q.delete();
    exp_overrun = 1'b0;
    check_reset_outputs("reset_mid_send");
    repeat (20) tick();
    check("no_free_after_reset", free_cyc, -1);

    // recovery after reset
    drain(1'b1, 1);
    wait_drained(100);

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_gbf_reader.md
# psum_gbf_reader

Read-side drain engine for the double-buffered psum global buffer. The su_adder stage writes completed partial sums into psum_gbf buffer 1 or 2 and signals completion. This block reads each completed buffer entry by entry. It serializes every wide psum word into narrower output beats on a valid/ready stream toward the off-chip/DMA path, then releases the buffer back to the writer.

## Interface
Parameters:
- PSUM_GBF_DATA_BITWIDTH, 512, width of one psum_gbf entry
- PSUM_GBF_ADDR_BITWIDTH, 5, psum_gbf address width
- PSUM_GBF_DEPTH, 32, entries per psum_gbf buffer (= 2^ADDR)
- OUT_DATA_BITWIDTH, 128, output beat width; PSUM_GBF_DATA_BITWIDTH must be an integer multiple (BEATS = ratio, ≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- buf_done  in  1  one-cycle pulse: a psum_gbf buffer is complete
- buf_done_num  in  1  completed buffer: 0 = buf1, 1 = buf2 (same encoding as psum_gbf_w_num)
- drain_len  in  ADDR+1  valid entries in completed buffer, sampled with buf_done
- rd_en1 / rd_en2  out  1  read enable, buffer 1 / 2
- rd_addr  out  ADDR  read address (shared)
- rd_data1 / rd_data2  in  PSUM_GBF_DATA_BITWIDTH  read data, 1-cycle latency
- out_valid  out  1  beat valid
- out_data  out  OUT_DATA_BITWIDTH  beat payload
- out_last  out  1  final beat of the buffer
- out_ready  in  1  downstream accepts beat
- buf1_free / buf2_free  out  1  one-cycle pulse: buffer drained, writer may reuse it
- overrun  out  1  sticky: buf_done hit a buffer already pending or draining
- clr_en  out  1  zero-write enable (see Configuration)
- clr_num  out  1  buffer targeted by clr_en
- clr_addr  out  ADDR  zero-write address

## Operation
- Two pending flags, one per buffer, plus stored len[b] (clamped to PSUM_GBF_DEPTH if larger). Set on buf_done.
  - If the target buffer is already pending or being drained: overrun ← 1, stored len unchanged, no new pending.
- Arbitration in IDLE: one pending buffer → select it. Both pending → select ~last_served. last_served resets to 1, so buf1 goes first.
- FSM states: IDLE, READ, WAIT, SEND, FREE.
  - IDLE → READ when a buffer is selected and len ≠ 0.
  - IDLE → FREE when a buffer is selected and len = 0.
  - READ: rd_enN = 1, rd_addr = entry counter. Next state WAIT.
  - WAIT: the selected rd_dataN is captured into the hold register at the end of the cycle. Next state SEND, beat counter = 0.
  - SEND: out_data = hold[beat*OUT +: OUT], LSB slice first. Beat advances on out_valid & out_ready.
    - After the last beat of an entry: if entry = len−1, go to FREE; else entry+1 and go to READ.
  - FREE: pulse bufN_free, clear pending[N], last_served ← N, go to IDLE.
- out_last = 1 only on the final beat of entry len−1.
- Beat fields (out_data, out_last) hold stable while out_valid & !out_ready.
- Reset mid-drain: drain aborted, pending cleared, no free pulse. The writer re-synchronises through its own reset.
- A buf_done pulse arriving in the same cycle as FREE for the other buffer is accepted normally.
- A buf_done for the buffer currently in FREE counts as overrun.

## Timing
- Reset values:
  - state = IDLE.
  - rd_en1, rd_en2, out_valid, out_last, buf1_free, buf2_free, overrun, clr_en = 0.
  - rd_addr, clr_addr, out_data = 0. clr_num = 0.
  - pending = 00, last_served = 1.
- All outputs are decoded from registered state and registers only; there is no combinational path from any input.
- buf_done in cycle T: pending set at the end of T, IDLE decides in T+1, rd_en in T+2, WAIT in T+3, first out_valid in T+4.
- Per entry with out_ready held high: READ + WAIT + BEATS = BEATS+2 cycles.
- Buffer total: len·(BEATS+2) + 1 FREE cycle, plus 1 IDLE cycle before the next buffer.
- out_ready low stalls only SEND. No reads are issued during a stall.

## Configuration
- PSUM_RD_CLEAR_EN defined: in each WAIT cycle, clr_en = 1, clr_num = selected buffer, clr_addr = address read in the preceding READ cycle. Every drained entry is zeroed, so the writer's init pass may be skipped. Requires a read-first psum_gbf port.
- PSUM_RD_CLEAR_EN undefined: clr_en, clr_num and clr_addr are tied to 0. Ports remain for interface stability.

## Structure
- Package psum_rd_pkg holds:
  - the state enum (IDLE, READ, WAIT, SEND, FREE);
  - a BEATS constant function;
  - the buffer-number encoding constants BUF1 = 0, BUF2 = 1.
- One sub-module: psum_beat_serializer, containing the hold register, beat counter, and out_valid/out_ready/last handling. Its load/done handshake goes to the top FSM.

## Test plan
- Single buffer, BEATS = 4: buf_done(num 0, len 2), out_ready = 1.
  - Expect 8 beats LSB-slice first, out_last only on beat 8.
  - First out_valid 4 cycles after buf_done; buf1_free 1 cycle after the last beat.
- Back-to-back: buf_done buf1 then buf2 (each len 1) two cycles apart.
  - Expect buf1 fully drained before buf2; buf1_free precedes buf2_free.
- Backpressure: toggle out_ready 1-0-0-1 during SEND.
  - Expect out_data/out_last constant while stalled, no beat lost or duplicated, rd_en low during the stall.
- Edge lengths:
  - len = 0 → no out_valid, buf2_free pulse within 2 cycles of IDLE selection.
  - len = 40 → clamped, exactly 32 entries read.
- Overrun and reset:
  - A second buf_done for a draining buffer sets overrun sticky while the drain completes unchanged.
  - Reset mid-SEND returns all outputs to reset values the next cycle, with no free pulse.
- With PSUM_RD_CLEAR_EN: clr_en fires once per entry with clr_addr 0..len−1 on the correct clr_num. Without the macro, clr_en is never asserted.
